snes_multi_src_encoder: RTL and testbench
=========================================

Name: snes_multi_src_encoder

Overview:
Parametrised successor to the single-byte SNES path. Accepts NUM_SRC controller sources (level-type such as the button board, and pulse-type such as the IR and keyboard decoders), holds pulse-type presses for a programmable time, and selects or merges the sources. It captures a stable 16-bit frame on the console latch and shifts it out on the console clock. It runs entirely on the internal oscillator clock, with the console's snes_clk and snes_latch synchronised internally.

Parameters:
NUM_SRC, 3, number of input sources (1..8)
BTN_W, 12, live buttons per source; frame bits BTN_W..15 are padding
SRC_PULSE, 3'b011, per-source mask: 1 = pulse-type (held via src_valid), 0 = level-type
HOLD_CYCLES, 208000, clk cycles a pulse-type press is held (~100 ms at 2.08 MHz); must be >= 1

Ports:
clk  input  1  internal oscillator clock
reset_n  input  1  asynchronous active-low reset
src_btn  input  NUM_SRC*BTN_W  source i occupies bits [i*BTN_W +: BTN_W]; active-high pressed
src_valid  input  NUM_SRC  one-cycle strobe; loads hold register of a pulse-type source; ignored for level-type
mode  input  2  0 = FIXED, 1 = MERGE, 2 = AUTO, 3 = treated as FIXED
sel  input  3  source index used in FIXED mode
snes_clk  input  1  console clock, asynchronous
snes_latch  input  1  console latch, asynchronous
snes_out  output  1  serial data to console; active-low (0 = pressed)
active_src  output  3  source currently driving the frame
frame_done  output  1  one-cycle pulse after the 16th shift of a frame

Behaviour:
- Reset values: all hold registers 0, hold counters 0, shift register all-unpressed, snes_out=1, active_src=0, frame_done=0, synchronisers 0.
- Synchronisers: each of snes_clk and snes_latch passes through a 2-flop synchroniser, then a rising-edge detector. Edge-to-action latency is 3 clk.
- Pulse sources: when src_valid[i] is high, hold_i <= slice i and cnt_i <= HOLD_CYCLES.
  - Otherwise, if cnt_i > 1, cnt_i decrements.
  - If cnt_i == 1, cnt_i <= 0 and hold_i <= 0 (the press ends).
  - If src_valid arrives in the same cycle the counter would expire, the reload wins.
  - A repeated valid extends the hold.
- Level sources: eff_i = the src_btn slice, combinational.
- Selection (combinational from eff_*):
  - FIXED: eff_sel. If sel >= NUM_SRC, all zeros and active_src=sel.
  - MERGE: bitwise OR of all eff_i. active_src = lowest index with a nonzero eff, else 0.
  - AUTO: a registered last_src updates to the lowest-indexed source whose eff goes from zero to nonzero in that cycle, then outputs eff_last_src. Reset value of last_src is 0.
- Frame: frame = {4'b0 padding-pressed-false, selected[BTN_W-1:0]}, zero-extended to 16 bits. Bit 0 is button B.
- Shift register (16 bits + 5-bit bit counter):
  - While the synchronised latch is high, the register parallel-loads the frame every cycle and the bit counter is set to 0.
  - On each synchronised snes_clk rising edge with latch low, the register shifts right. The fill value gives snes_out=0 after bit 15, matching console behaviour for a standard pad.
  - The bit counter saturates at 16. frame_done pulses in the cycle the counter reaches 16.
  - snes_out = ~shift[0].
  - A latch rise mid-frame reloads and restarts the frame; there is no error.
  - A clock edge coincident with a latch high is ignored.
- Selection changes mid-frame do not affect bits already captured.
- Asynchronous reset mid-frame forces snes_out=1 immediately. The next latch starts a clean frame.

Decomposition:
- Package snes_pkg:
  - FRAME_W=16.
  - Button index localparams: B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
  - typedef enum logic [1:0] {MODE_FIXED, MODE_MERGE, MODE_AUTO}.
- Sub-module snes_hold_reg (BTN_W, HOLD_CYCLES): hold register plus down-counter, instantiated per source under a generate on SRC_PULSE[i].

Test Plan:
- FIXED, sel=2, level src2=12'h001. Latch pulse, then 16 clocks -> snes_out samples 0,1,1,...,1 (16 bits). A 17th clock -> snes_out=0. frame_done pulses once.
- Pulse src0: src_valid with 12'h100 (A), HOLD_CYCLES=100 -> held for exactly 100 clk, then 0. A second valid at cycle 99 -> hold extends to cycle 199.
- MERGE: src0 pressed 12'h001, src1 pressed 12'h800 -> frame bits 0 and 11 pressed, active_src=0.
- AUTO: src1 becomes nonzero, then src0 becomes nonzero later -> active_src 1 then 0. Both becoming nonzero in the same cycle -> active_src=0.
- Latch re-asserted after 5 clocks -> bit counter restarts; the first bit is bit 0 of the new frame; no frame_done from the aborted frame.
- reset_n low during shift -> snes_out=1 immediately, all hold registers cleared. sel=5 in FIXED -> all bits unpressed (snes_out=1 for bits 0..15).

Source files
------------

// File: rtl/snes_multi_src_encoder_pkg.sv
// Shared types and constants for the multi-source SNES controller encoder.
// Button indices give the bit position of each button within the 16-bit frame.
package snes_pkg;

  localparam int FRAME_W = 16;

  localparam int B      = 0;
  localparam int Y      = 1;
  localparam int SELECT = 2;
  localparam int START  = 3;
  localparam int UP     = 4;
  localparam int DOWN   = 5;
  localparam int LEFT   = 6;
  localparam int RIGHT  = 7;
  localparam int A      = 8;
  localparam int X      = 9;
  localparam int L      = 10;
  localparam int R      = 11;

  typedef enum logic [1:0] {MODE_FIXED, MODE_MERGE, MODE_AUTO} mode_e;

endpackage

// File: rtl/snes_hold_reg.sv
// Press hold for a pulse-type source: a valid strobe captures the buttons and
// keeps them asserted for HOLD_CYCLES clocks; a new strobe restarts the hold.
module snes_hold_reg #(
  parameter int BTN_W       = 12,
  parameter int HOLD_CYCLES = 208000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [BTN_W-1:0] btn,
  output logic [BTN_W-1:0] held
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Reload has priority over expiry so a repeated press never drops a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      held <= '0;
    end else if (valid) begin
      cnt  <= CNT_W'(HOLD_CYCLES);
      held <= btn;
    end else if (cnt > CNT_W'(1)) begin
      cnt <= cnt - CNT_W'(1);
    end else if (cnt == CNT_W'(1)) begin
      cnt  <= '0;
      held <= '0;
    end
  end

endmodule

// File: rtl/snes_multi_src_encoder.sv
// Multi-source SNES pad encoder: holds pulse-type presses, selects or merges
// sources, and serialises a 16-bit frame on the synchronised console latch/clock.
module snes_multi_src_encoder
  import snes_pkg::*;
#(
  parameter int                 NUM_SRC     = 3,
  parameter int                 BTN_W       = 12,
  parameter logic [NUM_SRC-1:0] SRC_PULSE   = 3'b011,
  parameter int                 HOLD_CYCLES = 208000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*BTN_W-1:0] src_btn,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [1:0]               mode,
  input  logic [2:0]               sel,
  input  logic                     snes_clk,
  input  logic                     snes_latch,
  output logic                     snes_out,
  output logic [2:0]               active_src,
  output logic                     frame_done
);

  logic [NUM_SRC*BTN_W-1:0] eff;
  logic [NUM_SRC-1:0]       nz;
  logic [NUM_SRC-1:0]       nz_prev;
  logic [2:0]               last_src;
  logic [2:0]               next_last;
  logic [BTN_W-1:0]         selected;
  logic [FRAME_W-1:0]       frame;
  logic [FRAME_W-1:0]       shift;
  logic [4:0]               bit_cnt;
  logic [2:0]               sclk_sync;
  logic [1:0]               latch_sync;
  logic                     latch_hi;
  logic                     clk_rise;

  // Per-source effective buttons: held register for pulse sources, live for level.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    if (SRC_PULSE[i]) begin : g_pulse
      snes_hold_reg #(
        .BTN_W      (BTN_W),
        .HOLD_CYCLES(HOLD_CYCLES)
      ) u_hold (
        .clk    (clk),
        .reset_n(reset_n),
        .valid  (src_valid[i]),
        .btn    (src_btn[i*BTN_W +: BTN_W]),
        .held   (eff[i*BTN_W +: BTN_W])
      );
    end else begin : g_level
      assign eff[i*BTN_W +: BTN_W] = src_btn[i*BTN_W +: BTN_W];
    end
    assign nz[i] = |eff[i*BTN_W +: BTN_W];
  end

  // AUTO follows the lowest-indexed source that just went from idle to pressed.
  always_comb begin
    next_last = last_src;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (nz[i] && !nz_prev[i]) next_last = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nz_prev  <= '0;
      last_src <= '0;
    end else begin
      nz_prev  <= nz;
      last_src <= next_last;
    end
  end

  always_comb begin
    selected   = '0;
    active_src = '0;
    case (mode_e'(mode))
      MODE_MERGE: begin
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          selected = selected | eff[i*BTN_W +: BTN_W];
          if (nz[i]) active_src = 3'(i);
        end
      end
      MODE_AUTO: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (last_src == 3'(i)) selected = eff[i*BTN_W +: BTN_W];
        end
        active_src = last_src;
      end
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (sel == 3'(i)) selected = eff[i*BTN_W +: BTN_W];
        end
        active_src = sel;
      end
    endcase
  end

  assign frame = FRAME_W'(selected);

  // Console strobes: two-flop synchronisers, plus a third flop for clock edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync  <= '0;
      latch_sync <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[1:0], snes_clk};
      latch_sync <= {latch_sync[0], snes_latch};
    end
  end

  assign latch_hi = latch_sync[1];
  assign clk_rise = sclk_sync[1] & ~sclk_sync[2];

  // Fill with pressed bits so the line reads low once all 16 bits are out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (latch_hi) begin
      shift      <= frame;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (clk_rise) begin
      shift      <= {1'b1, shift[FRAME_W-1:1]};
      if (bit_cnt < 5'd16) bit_cnt <= bit_cnt + 5'd1;
      frame_done <= (bit_cnt == 5'd15);
    end else begin
      frame_done <= 1'b0;
    end
  end

  assign snes_out = ~shift[0];

endmodule

// File: tb/tb_snes_multi_src_encoder.sv
// Directed bench for snes_multi_src_encoder: frame shifting, press hold,
// source selection modes, frame restart and mid-frame reset.
module tb_snes_multi_src_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [35:0] src_btn = '0;
  logic [2:0]  src_valid = '0;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  sel = 3'd0;
  logic        snes_clk = 1'b0;
  logic        snes_latch = 1'b0;
  logic        snes_out;
  logic [2:0]  active_src;
  logic        frame_done;

  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [15:0] word;

  snes_multi_src_encoder #(
    .NUM_SRC    (3),
    .BTN_W      (12),
    .SRC_PULSE  (3'b011),
    .HOLD_CYCLES(100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_btn   (src_btn),
    .src_valid (src_valid),
    .mode      (mode),
    .sel       (sel),
    .snes_clk  (snes_clk),
    .snes_latch(snes_latch),
    .snes_out  (snes_out),
    .active_src(active_src),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic latch_pulse();
    snes_latch = 1'b1;
    repeat (6) @(negedge clk);
    snes_latch = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic clk_pulse();
    snes_clk = 1'b1;
    repeat (6) @(negedge clk);
    snes_clk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Bit i of w is the line level presented before the (i+1)-th console clock.
  task automatic read_word(output logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      w[i] = snes_out;
      clk_pulse();
    end
  endtask

  task automatic pulse_src(input logic [2:0] mask, input logic [11:0] v0, input logic [11:0] v1);
    src_btn[11:0]  = v0;
    src_btn[23:12] = v1;
    src_valid      = mask;
    @(negedge clk);
    src_valid      = '0;
    src_btn[23:0]  = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_snes_out", 32'(snes_out), 32'd1);
    chk("reset_active_src", 32'(active_src), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // FIXED, level source 2 with B pressed
    mode = 2'd0; sel = 3'd2; src_btn[35:24] = 12'h001;
    done_cnt = 0;
    latch_pulse();
    read_word(word);
    chk("fixed_word", 32'(word), 32'h0000_FFFE);
    chk("fixed_done_once", 32'(done_cnt), 32'd1);
    clk_pulse();
    chk("fixed_bit17_low", 32'(snes_out), 32'd0);
    chk("fixed_no_extra_done", 32'(done_cnt), 32'd1);

    // Pulse hold on source 0, observed through MERGE active_src
    mode = 2'd1;
    pulse_src(3'b001, 12'h100, 12'h000);
    chk("hold_first", 32'(active_src), 32'd0);
    repeat (99) @(negedge clk);
    chk("hold_last", 32'(active_src), 32'd0);
    @(negedge clk);
    chk("hold_expired", 32'(active_src), 32'd2);
    pulse_src(3'b001, 12'h100, 12'h000);
    repeat (98) @(negedge clk);
    pulse_src(3'b001, 12'h100, 12'h000);
    repeat (99) @(negedge clk);
    chk("hold_ext_last", 32'(active_src), 32'd0);
    @(negedge clk);
    chk("hold_ext_expired", 32'(active_src), 32'd2);

    // MERGE of B from source 0 and R from source 1
    src_btn[35:24] = 12'h000;
    pulse_src(3'b011, 12'h001, 12'h800);
    latch_pulse();
    chk("merge_active", 32'(active_src), 32'd0);
    read_word(word);
    chk("merge_word", 32'(word), 32'h0000_F7FE);

    // AUTO tracking of newly pressed sources
    repeat (110) @(negedge clk);
    mode = 2'd2;
    pulse_src(3'b010, 12'h000, 12'h010);
    repeat (3) @(negedge clk);
    chk("auto_src1", 32'(active_src), 32'd1);
    pulse_src(3'b001, 12'h020, 12'h000);
    repeat (3) @(negedge clk);
    chk("auto_src0", 32'(active_src), 32'd0);
    repeat (110) @(negedge clk);
    src_btn[35:24] = 12'h040;
    repeat (3) @(negedge clk);
    chk("auto_src2", 32'(active_src), 32'd2);
    src_btn[35:24] = 12'h000;
    repeat (3) @(negedge clk);
    pulse_src(3'b011, 12'h001, 12'h002);
    repeat (3) @(negedge clk);
    chk("auto_tie_lowest", 32'(active_src), 32'd0);

    // Latch re-asserted mid-frame restarts with the new frame
    mode = 2'd0; sel = 3'd2; src_btn[35:24] = 12'h003;
    done_cnt = 0;
    latch_pulse();
    repeat (5) clk_pulse();
    src_btn[35:24] = 12'h004;
    latch_pulse();
    read_word(word);
    chk("relatch_word", 32'(word), 32'h0000_FFFB);
    chk("relatch_done_once", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of a frame
    repeat (110) @(negedge clk);
    mode = 2'd1; src_btn[35:24] = 12'h001;
    pulse_src(3'b001, 12'h100, 12'h000);
    latch_pulse();
    chk("pre_reset_out", 32'(snes_out), 32'd0);
    chk("pre_reset_active", 32'(active_src), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid_out", 32'(snes_out), 32'd1);
    chk("reset_clears_hold", 32'(active_src), 32'd2);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Out-of-range FIXED selection gives an all-released frame
    mode = 2'd0; sel = 3'd5;
    latch_pulse();
    chk("sel5_active", 32'(active_src), 32'd5);
    read_word(word);
    chk("sel5_word", 32'(word), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
